// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: iterative unsigned MUL/MULHU/DIVU/REMU execute unit.
// One op in flight; produces a one-cycle register-file write-back command.
module seq_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [1:0]       funct,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [AW-1:0]    rd_addr,
  output logic             busy,
  output logic             wb_en,
  output logic [AW-1:0]    wb_reg,
  output logic [WIDTH-1:0] wb_data
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_WB
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_funct;
  logic [AW-1:0]    r_rd;
  // r_a: multiplicand / divisor
  logic [WIDTH-1:0] r_a;
  // r_lo: multiplier -> product low / dividend -> quotient
  logic [WIDTH-1:0] r_lo;
  // r_hi: product high / remainder
  logic [WIDTH-1:0] r_hi;
  logic             r_busy;
  logic             r_wb_en;
  logic [AW-1:0]    r_wb_reg;
  logic [WIDTH-1:0] r_wb_data;

  logic [WIDTH-1:0] w_mpart;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_dshift;
  logic             w_dge;
  logic [WIDTH-1:0] w_ddiff;
  logic [WIDTH-1:0] w_result;
  logic             w_is_div;

  // One shift-add or restoring-subtract step, plus result selection
  always_comb begin
    w_is_div = r_funct[1];
    w_mpart  = r_lo[0] ? r_a : '0;
    w_madd   = {1'b0, r_hi} + {1'b0, w_mpart};
    w_dshift = {r_hi, r_lo[WIDTH-1]};
    w_dge    = (w_dshift >= {1'b0, r_a});
    w_ddiff  = w_dshift[WIDTH-1:0] - r_a;
    w_result = r_funct[0] ? r_hi : r_lo;
  end

  // Control FSM, datapath registers and registered write-back outputs
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_funct   <= '0;
      r_rd      <= '0;
      r_a       <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_busy    <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_reg  <= '0;
      r_wb_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_wb_en <= 1'b0;
          if (start) begin
            r_funct <= funct;
            r_rd    <= rd_addr;
            r_a     <= rs2_data;
            r_lo    <= rs1_data;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (w_is_div) begin
            r_hi <= w_dge ? w_ddiff : w_dshift[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_dge};
          end else begin
            {r_hi, r_lo} <= {w_madd, r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_wb_en   <= 1'b1;
          r_wb_reg  <= r_rd;
          r_wb_data <= w_result;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_wb_en <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign wb_en   = r_wb_en;
  assign wb_reg  = r_wb_reg;
  assign wb_data = r_wb_data;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// tb_seq_muldiv_unit: directed bench for seq_muldiv_unit.
// Cycle-level reference model plus literal result checks.
module tb_seq_muldiv_unit;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    funct = '0;
  logic [W-1:0]  rs1_data = '0;
  logic [W-1:0]  rs2_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          busy;
  logic          wb_en;
  logic [AW-1:0] wb_reg;
  logic [W-1:0]  wb_data;

  seq_muldiv_unit #(.WIDTH(W), .AW(AW)) dut (
    .clk(clk),
    .clr_n(clr_n),
    .start(start),
    .funct(funct),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .rd_addr(rd_addr),
    .busy(busy),
    .wb_en(wb_en),
    .wb_reg(wb_reg),
    .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int pulses = 0;
  bit chk_en = 1'b0;
  logic [W-1:0] rf [32];
  logic [W-1:0] last_data;
  logic [AW-1:0] last_reg;

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_result(
    logic [1:0] f, logic [W-1:0] a, logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = 64'(a) * 64'(b);
    case (f)
      2'b00: return p[W-1:0];
      2'b01: return p[2*W-1:W];
      2'b10: return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Reference model: countdown from acceptance to write-back
  int           m_left = 0;
  logic         m_busy = 1'b0;
  logic         m_wb_en = 1'b0;
  logic [AW-1:0] m_wb_reg = '0;
  logic [W-1:0] m_wb_data = '0;
  logic [AW-1:0] m_pend_reg = '0;
  logic [W-1:0] m_pend_data = '0;

  always @(posedge clk) begin
    if (!clr_n) begin
      m_left = 0;
      m_wb_en = 1'b0;
      m_wb_reg = '0;
      m_wb_data = '0;
    end else begin
      m_wb_en = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_wb_en = 1'b1;
          m_wb_reg = m_pend_reg;
          m_wb_data = m_pend_data;
        end
      end else if (start) begin
        m_left = LAT;
        m_pend_reg = rd_addr;
        m_pend_data = ref_result(funct, rs1_data, rs2_data);
      end
    end
    m_busy = (m_left != 0);
  end

  // Compare process plus register-file write model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", W'(busy), W'(m_busy));
      check("wb_en", W'(wb_en), W'(m_wb_en));
      check("wb_reg", W'(wb_reg), W'(m_wb_reg));
      check("wb_data", wb_data, m_wb_data);
    end
    if (wb_en === 1'b1) begin
      pulses++;
      rf[wb_reg] = wb_data;
      last_data = wb_data;
      last_reg = wb_reg;
    end
  end

  task automatic issue(logic [1:0] f, logic [W-1:0] a, logic [W-1:0] b,
                       logic [AW-1:0] rd);
    @(posedge clk); #2;
    funct = f; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    funct = ~f; rs1_data = ~a; rs2_data = 32'h5; rd_addr = ~rd;
  endtask

  task automatic wait_wb(string name, int budget);
    int p0;
    p0 = pulses;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (pulses != p0) return;
    end
    n_assert++;
    n_fail++;
    $display("FAIL %s: timeout got no wb_en expected one", name);
  endtask

  task automatic run_op(string name, logic [1:0] f, logic [W-1:0] a,
                        logic [W-1:0] b, logic [AW-1:0] rd,
                        logic [W-1:0] exp);
    issue(f, a, b, rd);
    wait_wb(name, LAT + 10);
    check(name, last_data, exp);
    check({name, "_rd"}, W'(last_reg), W'(rd));
  endtask

  initial begin
    int p0;
    clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 clr_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", W'(busy), '0);
    check("rst_wb_en", W'(wb_en), '0);
    check("rst_wb_reg", W'(wb_reg), '0);
    check("rst_wb_data", wb_data, '0);

    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd3, 32'd42);
    check("rf_r3", rf[3], 32'd42);
    run_op("mulhu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,
           32'hFFFFFFFE);
    run_op("mul_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,
           32'h00000001);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 5'd6, 32'd14);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd7, 32'd2);
    run_op("divu_msb", 2'b10, 32'h80000000, 32'd1, 5'd8, 32'h80000000);
    run_op("remu_msb", 2'b11, 32'h80000000, 32'd1, 5'd9, 32'd0);
    run_op("divu_by0", 2'b10, 32'h12345678, 32'd0, 5'd10, 32'hFFFFFFFF);
    run_op("remu_by0", 2'b11, 32'h12345678, 32'd0, 5'd11, 32'h12345678);
    run_op("divu_small", 2'b10, 32'd5, 32'd9, 5'd0, 32'd0);
    run_op("remu_small", 2'b11, 32'd5, 32'd9, 5'd0, 32'd5);
    run_op("mulhu_mix", 2'b01, 32'h89ABCDEF, 32'h12345678, 5'd31,
           32'h09CA39E0);

    // Second start while busy must be ignored
    p0 = pulses;
    issue(2'b00, 32'd7, 32'd6, 5'd3);
    repeat (3) @(posedge clk);
    #2 start = 1'b1; rd_addr = 5'd9; funct = 2'b01;
    rs1_data = 32'd100; rs2_data = 32'd100;
    @(posedge clk); #2 start = 1'b0;
    wait_wb("busy_ign", LAT + 10);
    repeat (LAT + 5) @(negedge clk);
    #1;
    check("busy_pulses", W'(pulses - p0), 32'd1);
    check("busy_rd", W'(last_reg), 32'd3);
    check("busy_data", last_data, 32'd42);

    // Reset mid-calculation aborts the op
    p0 = pulses;
    issue(2'b10, 32'd1000, 32'd10, 5'd12);
    repeat (9) @(posedge clk);
    #2 clr_n = 1'b0;
    @(posedge clk); #2 clr_n = 1'b1;
    repeat (LAT + 10) @(negedge clk);
    #1;
    check("abort_pulses", W'(pulses - p0), 32'd0);
    run_op("after_abort", 2'b10, 32'd1000, 32'd10, 5'd12, 32'd100);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
